sram_arbiter: RTL and testbench

- Sequences the external 8-bit asynchronous SRAM (ER_* pins) and shares it between two requesters: the CPU bus (port C) and an auxiliary master (port X), e.g. a loader or DMA engine.
- Generates ER_CS/ER_OE/ER_WE timing with programmable strobe width and turnaround gaps, latches address and data per access, and returns read data with a one-cycle ack pulse.
- Sits between the address/data muxing and the SRAM pads; the top level keeps its PROG override ahead of this block.

---
 rtl/sram_arbiter_if.sv | 16 +
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter; one instance per requesting master.
// Handshake: the master raises req with we/add/di stable and holds them until ack (one-cycle
// pulse); the slave latches them only at grant, returns read data on dout together with ack.
interface sram_arbiter_if #(
    parameter int AW = 19
);
    logic          req;
    logic          we;
    logic [AW-1:0] add;
    logic [7:0]    di;
    logic [7:0]    dout;
    logic          ack;

    modport master (output req, we, add, di, input dout, ack);
    modport slave  (input req, we, add, di, output dout, ack);
endinterface

// File: rtl/sram_arbiter.sv
// Shares an 8-bit async SRAM between the CPU port (c) and an auxiliary port (x).
// Optional macro SRAM_ARB_RR_EN: round-robin arbitration instead of fixed C-over-X priority.
module sram_arbiter #(
    parameter int AW       = 19,
    parameter int WAIT_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic           CLK20,
    input  logic           CRST,
    sram_arbiter_if.slave  c,
    sram_arbiter_if.slave  x,
    output logic [AW-1:0]  ER_ADD,
    output logic [7:0]     ER_DO,
    output logic           ER_DOE,
    input  logic [7:0]     ER_DI,
    output logic           ER_CS,
    output logic           ER_OE,
    output logic           ER_WE,
    output logic           busy,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       sel_x;
    logic       acc_we;
    logic       grant_c;
    logic       grant_x;

`ifdef SRAM_ARB_RR_EN
    logic last_x;

    // Contention goes to whichever port was not served last; a lone requester always wins.
    always_comb begin
        grant_c = c.req && (!x.req || last_x);
        grant_x = x.req && !grant_c;
    end

    always_ff @(posedge CLK20 or negedge CRST) begin
        if (!CRST) begin
            last_x <= 1'b1;
        end else if (state == S_IDLE && (grant_c || grant_x)) begin
            last_x <= grant_x;
        end
    end
`else
    always_comb begin
        grant_c = c.req;
        grant_x = x.req && !c.req;
    end
`endif

    assign dbg_state = state;

    always_ff @(posedge CLK20 or negedge CRST) begin
        if (!CRST) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            sel_x  <= 1'b0;
            acc_we <= 1'b0;
            ER_ADD <= '0;
            ER_DO  <= 8'h00;
            ER_DOE <= 1'b0;
            ER_CS  <= 1'b1;
            ER_OE  <= 1'b1;
            ER_WE  <= 1'b1;
            busy   <= 1'b0;
            c.dout <= 8'h00;
            c.ack  <= 1'b0;
            x.dout <= 8'h00;
            x.ack  <= 1'b0;
        end else begin
            c.ack <= 1'b0;
            x.ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_c || grant_x) begin
                        sel_x  <= grant_x;
                        acc_we <= grant_x ? x.we : c.we;
                        ER_ADD <= grant_x ? x.add : c.add;
                        ER_DO  <= grant_x ? x.di : c.di;
                        ER_DOE <= grant_x ? x.we : c.we;
                        ER_CS  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt <= 4'(WAIT_CYC - 1);
                    if (acc_we) ER_WE <= 1'b0;
                    else        ER_OE <= 1'b0;
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    if (cnt == 4'd0) begin
                        ER_WE <= 1'b1;
                        ER_OE <= 1'b1;
                        // Read data is sampled on the same edge that releases ER_OE.
                        if (sel_x) begin
                            x.ack <= 1'b1;
                            if (!acc_we) x.dout <= ER_DI;
                        end else begin
                            c.ack <= 1'b1;
                            if (!acc_we) c.dout <= ER_DI;
                        end
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    ER_CS  <= 1'b1;
                    ER_DOE <= 1'b0;
                    if (TURN_CYC == 0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= 4'(TURN_CYC - 1);
                        state <= S_TURN;
                    end
                end
                S_TURN: begin
                    if (cnt == 4'd0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: instance 0 uses TURN_CYC=1, instance 1 uses TURN_CYC=0.
module tb_sram_arbiter;
    localparam int AW = 19;
    localparam int W  = 2;
    localparam int T  = 1;

    logic CLK20 = 1'b0;
    logic CRST  = 1'b0;
    always #25 CLK20 = ~CLK20;

    sram_arbiter_if #(.AW(AW)) c_if ();
    sram_arbiter_if #(.AW(AW)) x_if ();
    sram_arbiter_if #(.AW(AW)) c2_if ();
    sram_arbiter_if #(.AW(AW)) x2_if ();

    logic [AW-1:0] er_add [0:1];
    logic [7:0]    er_do  [0:1];
    logic [7:0]    er_di  [0:1];
    logic          er_doe [0:1];
    logic          er_cs  [0:1];
    logic          er_oe  [0:1];
    logic          er_we  [0:1];
    logic          busy   [0:1];
    logic [2:0]    dbg    [0:1];

    sram_arbiter #(.AW(AW), .WAIT_CYC(W), .TURN_CYC(T)) dut (
        .CLK20(CLK20), .CRST(CRST), .c(c_if), .x(x_if),
        .ER_ADD(er_add[0]), .ER_DO(er_do[0]), .ER_DOE(er_doe[0]), .ER_DI(er_di[0]),
        .ER_CS(er_cs[0]), .ER_OE(er_oe[0]), .ER_WE(er_we[0]), .busy(busy[0]),
        .dbg_state(dbg[0])
    );

    sram_arbiter #(.AW(AW), .WAIT_CYC(W), .TURN_CYC(0)) dut_t0 (
        .CLK20(CLK20), .CRST(CRST), .c(c2_if), .x(x2_if),
        .ER_ADD(er_add[1]), .ER_DO(er_do[1]), .ER_DOE(er_doe[1]), .ER_DI(er_di[1]),
        .ER_CS(er_cs[1]), .ER_OE(er_oe[1]), .ER_WE(er_we[1]), .busy(busy[1]),
        .dbg_state(dbg[1])
    );

    // SRAM contents: a few fixed cells, everything else is the low address byte xor 0x5A.
    function automatic logic [7:0] sram_val(input logic [AW-1:0] a);
        case (a)
            19'h7FFFF: return 8'h3C;
            19'h00010: return 8'h11;
            19'h00011: return 8'h22;
            default:   return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign er_di[0] = sram_val(er_add[0]);
    assign er_di[1] = sram_val(er_add[1]);

    // ---------------- pad monitor ----------------
    int            cyc;
    int            we_low [0:1];
    int            oe_low [0:1];
    int            doe_cyc [0:1];
    int            cs_high [0:1];
    int            pad_bad [0:1];
    int            prot_bad [0:1];
    logic [AW-1:0] cur_add;
    logic [7:0]    cur_di;
    logic          cur_we;

    always @(negedge CLK20) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!er_we[d])  we_low[d]++;
            if (!er_oe[d])  oe_low[d]++;
            if (er_doe[d])  doe_cyc[d]++;
            if (er_cs[d]) begin
                cs_high[d]++;
            end else begin
                if (er_add[d] !== cur_add) pad_bad[d]++;
                if (cur_we && (er_do[d] !== cur_di || er_doe[d] !== 1'b1)) pad_bad[d]++;
                if (!cur_we && er_doe[d]) pad_bad[d]++;
            end
            if ((!er_we[d] && !er_oe[d]) || (er_doe[d] && !er_oe[d])) prot_bad[d]++;
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // sel: 0 = instance 0 port C, 1 = instance 0 port X, 2 = instance 1 port C
    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [AW-1:0] add, input logic [7:0] di);
        case (sel)
            0: begin c_if.req = req;  c_if.we = we;  c_if.add = add;  c_if.di = di;  end
            1: begin x_if.req = req;  x_if.we = we;  x_if.add = add;  x_if.di = di;  end
            default: begin c2_if.req = req; c2_if.we = we; c2_if.add = add; c2_if.di = di; end
        endcase
    endtask

    function automatic logic get_ack(input int sel);
        case (sel)
            0:       return c_if.ack;
            1:       return x_if.ack;
            default: return c2_if.ack;
        endcase
    endfunction

    function automatic logic [7:0] get_do(input int sel);
        case (sel)
            0:       return c_if.dout;
            1:       return x_if.dout;
            default: return c2_if.dout;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 2) ? busy[1] : busy[0];
    endfunction

    task automatic tick();
        @(negedge CLK20);
        #1;
    endtask

    // Waits for idle, raises req, counts cycles up to the ack (lat = -1 on timeout).
    task automatic access(input int sel, input logic we, input logic [AW-1:0] add,
                          input logic [7:0] di, input bit keep_req,
                          output int lat, output logic [7:0] rd);
        int d;
        int k;
        d   = (sel == 2) ? 1 : 0;
        lat = -1;
        k   = 0;
        while (get_busy(sel) && k < 100) begin
            tick();
            k++;
        end
        cur_add = add;
        cur_di  = di;
        cur_we  = we;
        we_low[d] = 0; oe_low[d] = 0; doe_cyc[d] = 0; pad_bad[d] = 0; prot_bad[d] = 0;
        drive(sel, 1'b1, we, add, di);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (get_ack(sel)) begin
                lat = i;
                break;
            end
        end
        rd = get_do(sel);
        if (!keep_req) drive(sel, 1'b0, we, add, di);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            sel;
        logic          we;
        logic [AW-1:0] add;
        logic [7:0]    di;
        logic [7:0]    rd;
    } vec_t;

    vec_t       vt [6];
    logic [7:0] model_do [0:1];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         lat2;
        int         c1;
        int         got [4];
        int         n;
        logic [7:0] rd;
        logic [7:0] rd2;

        vt[0] = '{0, 1'b1, 19'h0F800, 8'hA5, 8'h00};
        vt[1] = '{1, 1'b0, 19'h7FFFF, 8'h00, 8'h3C};
        vt[2] = '{0, 1'b0, 19'h12345, 8'h00, 8'h1F};
        vt[3] = '{1, 1'b1, 19'h40000, 8'hFF, 8'h00};
        vt[4] = '{0, 1'b0, 19'h7FFFF, 8'h00, 8'h3C};
        vt[5] = '{1, 1'b0, 19'h00000, 8'h00, 8'h5A};
        model_do[0] = 8'h00;
        model_do[1] = 8'h00;
        cur_add = '0; cur_di = 8'h00; cur_we = 1'b0;

        drive(0, 1'b0, 1'b0, '0, 8'h00);
        drive(1, 1'b0, 1'b0, '0, 8'h00);
        drive(2, 1'b0, 1'b0, '0, 8'h00);
        x2_if.req = 1'b0; x2_if.we = 1'b0; x2_if.add = '0; x2_if.di = 8'h00;

        // Reset held, then released with no requests.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_strobes", {er_cs[0], er_oe[0], er_we[0], er_doe[0], busy[0], c_if.ack, x_if.ack},
                7'b1110000);
            chk("rst_bus", {er_add[0], er_do[0], c_if.dout, x_if.dout}, 0);
        end
        CRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_strobes", {er_cs[0], er_oe[0], er_we[0], er_doe[0], busy[0], c_if.ack, x_if.ack,
                                 er_cs[1], busy[1], c2_if.ack}, 10'b1110000100);
        end

        // Single accesses from the table.
        for (int i = 0; i < 6; i++) begin
            access(vt[i].sel, vt[i].we, vt[i].add, vt[i].di, 1'b0, lat, rd);
            chk($sformatf("v%0d_lat", i), lat, 2 + W);
            if (!vt[i].we) model_do[vt[i].sel] = vt[i].rd;
            chk($sformatf("v%0d_do", i), rd, model_do[vt[i].sel]);
            chk($sformatf("v%0d_other_do", i), get_do(1 - vt[i].sel), model_do[1 - vt[i].sel]);
            chk($sformatf("v%0d_we_low", i), we_low[0], vt[i].we ? W : 0);
            chk($sformatf("v%0d_oe_low", i), oe_low[0], vt[i].we ? 0 : W);
            chk($sformatf("v%0d_doe_cyc", i), doe_cyc[0], vt[i].we ? W + 2 : 0);
            chk($sformatf("v%0d_pads", i), pad_bad[0], 0);
            chk($sformatf("v%0d_protocol", i), prot_bad[0], 0);
        end

        // Reset during the second STROBE cycle of a write; access restarts after release.
        while (busy[0]) tick();
        cur_add = 19'h0ABCD; cur_di = 8'h3E; cur_we = 1'b1;
        drive(0, 1'b1, 1'b1, 19'h0ABCD, 8'h3E);
        tick();
        tick();
        tick();
        chk("mid_strobe_we", er_we[0], 1'b0);
        CRST = 1'b0;
        #1;
        chk("mid_rst_pads", {er_we[0], er_cs[0], er_doe[0], busy[0], c_if.ack}, 5'b11000);
        tick();
        chk("mid_rst_hold", {er_we[0], er_cs[0], c_if.ack}, 3'b110);
        CRST = 1'b1;
        we_low[0] = 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (c_if.ack) begin
                lat = i;
                break;
            end
        end
        drive(0, 1'b0, 1'b1, 19'h0ABCD, 8'h3E);
        chk("restart_lat", lat, 2 + W);
        chk("restart_we_low", we_low[0], W);

        // Both ports requesting continuously, starting from reset.
        while (busy[0]) tick();
        CRST = 1'b0;
        tick();
        CRST = 1'b1;
        drive(0, 1'b1, 1'b0, 19'h00100, 8'h00);
        drive(1, 1'b1, 1'b0, 19'h00200, 8'h00);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            if (c_if.ack && n < 4) begin got[n] = 0; n++; end
            if (x_if.ack && n < 4) begin got[n] = 1; n++; end
        end
        drive(0, 1'b0, 1'b0, 19'h00100, 8'h00);
        drive(1, 1'b0, 1'b0, 19'h00200, 8'h00);
        chk("arb_count", n, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
            chk($sformatf("arb_grant%0d", i), (n > i) ? got[i] : -1, i % 2);
`else
            chk($sformatf("arb_grant%0d", i), (n > i) ? got[i] : -1, 0);
`endif
        end

        // TURN_CYC = 0: back-to-back reads on the second instance.
        access(2, 1'b0, 19'h00010, 8'h00, 1'b1, lat, rd);
        c1 = cyc;
        cs_high[1] = 0;
        access(2, 1'b0, 19'h00011, 8'h00, 1'b0, lat2, rd2);
        chk("t0_lat1", lat, 2 + W);
        chk("t0_rd1", rd, 8'h11);
        chk("t0_lat2", lat2, 2 + W);
        chk("t0_rd2", rd2, 8'h22);
        chk("t0_gap", cyc - c1, 3 + W);
        chk("t0_cs_high", cs_high[1], 1);
        chk("t0_protocol", prot_bad[1], 0);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
